// File: rtl/xrmem_arb_rr.sv
// XR bus arbiter: N requesters, fixed or round-robin priority, with a two-stage
// grant -> bank strobe -> ack pipeline and per-bank video read blocking.
module xrmem_arb_rr #(
  parameter int unsigned           NUM_REQ = 3,
  parameter int unsigned           BANK_W  = 3,
  parameter bit                    RR_EN   = 1'b1,
  parameter logic [(2**BANK_W)-1:0] WR_MASK = 8'hFF
) (
  input  logic                      clk,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_sel_i,
  input  logic [NUM_REQ-1:0]        req_wr_i,
  input  logic [NUM_REQ*16-1:0]     req_addr_i,
  input  logic [NUM_REQ*16-1:0]     req_data_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [15:0]               req_data_o,
  output logic                      err_o,
  input  logic [(2**BANK_W)-1:0]    vid_busy_i,
  output logic [(2**BANK_W)-1:0]    mem_rd_o,
  output logic [(2**BANK_W)-1:0]    mem_wr_o,
  output logic [15:0]               mem_addr_o,
  output logic [15:0]               mem_data_o,
  input  logic [(2**BANK_W)*16-1:0] mem_rdata_i
);

  localparam int unsigned NUM_BANK = 2**BANK_W;
  localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] inflight_q, inflight_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               s1_vld_q, s1_vld_d;
  logic               s1_wr_q, s1_wr_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic [BANK_W-1:0]  s1_bank_q, s1_bank_d;
  logic [15:0]        s1_addr_q, s1_addr_d;
  logic [15:0]        s1_data_q, s1_data_d;
  logic               s2_vld_q, s2_vld_d;
  logic               s2_rd_q, s2_rd_d;
  logic               s2_err_q, s2_err_d;
  logic [ID_W-1:0]    s2_id_q, s2_id_d;
  logic [BANK_W-1:0]  s2_bank_q, s2_bank_d;
  logic [15:0]        rdata_q, rdata_d;

  logic [NUM_REQ-1:0] ack_vec;
  logic [NUM_REQ-1:0] elig;
  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_wr;
  logic [15:0]        gnt_addr;
  logic [15:0]        gnt_data;
  int unsigned        cand;
  logic [ID_W-1:0]    cand_id;
  logic [15:0]        bank_rdata;

  always_comb begin
    ack_vec = '0;
    if (s2_vld_q) ack_vec[s2_id_q] = 1'b1;
  end

  // A requester being acked is still in flight this cycle; the ack term keeps
  // the rule explicit should the inflight clear ever move earlier.
  always_comb begin
    elig = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      elig[r] = req_sel_i[r] && !inflight_q[r] && !ack_vec[r] &&
                (req_wr_i[r] || !vid_busy_i[req_addr_i[r*16+15 -: BANK_W]]);
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = 0;
    cand_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand    = RR_EN ? (32'(ptr_q) + 1 + i) % NUM_REQ : i;
      cand_id = cand[ID_W-1:0];
      if (!gnt_vld && elig[cand_id]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand_id;
      end
    end
  end

  always_comb begin
    gnt_wr   = 1'b0;
    gnt_addr = '0;
    gnt_data = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (ID_W'(r) == gnt_id) begin
        gnt_wr   = req_wr_i[r];
        gnt_addr = req_addr_i[r*16 +: 16];
        gnt_data = req_data_i[r*16 +: 16];
      end
    end
  end

  always_comb begin
    bank_rdata = '0;
    for (int unsigned b = 0; b < NUM_BANK; b++) begin
      if (BANK_W'(b) == s2_bank_q) bank_rdata = mem_rdata_i[b*16 +: 16];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (s2_vld_q) inflight_d[s2_id_q] = 1'b0;
    if (gnt_vld)  inflight_d[gnt_id]  = 1'b1;
    ptr_d     = gnt_vld ? gnt_id : ptr_q;
    s1_vld_d  = gnt_vld;
    s1_id_d   = gnt_vld ? gnt_id : s1_id_q;
    s1_wr_d   = gnt_vld ? gnt_wr : s1_wr_q;
    s1_addr_d = gnt_vld ? gnt_addr : s1_addr_q;
    s1_data_d = gnt_vld ? gnt_data : s1_data_q;
    s1_bank_d = gnt_vld ? gnt_addr[15 -: BANK_W] : s1_bank_q;
    s2_vld_d  = s1_vld_q;
    s2_rd_d   = s1_vld_q && !s1_wr_q;
    s2_err_d  = s1_vld_q && s1_wr_q && !WR_MASK[s1_bank_q];
    s2_id_d   = s1_id_q;
    s2_bank_d = s1_bank_q;
    rdata_d   = s2_rd_q ? bank_rdata : rdata_q;
  end

  // Outputs are forced low while reset is asserted so a grant issued just
  // before reset never reaches a bank or a requester.
  always_comb begin
    req_ack_o  = '0;
    req_data_o = '0;
    err_o      = 1'b0;
    mem_rd_o   = '0;
    mem_wr_o   = '0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (!reset_i) begin
      req_ack_o  = ack_vec;
      req_data_o = rdata_d;
      err_o      = s2_err_q;
      mem_addr_o = s1_addr_q;
      mem_data_o = s1_data_q;
      if (s1_vld_q && !s1_wr_q)                     mem_rd_o[s1_bank_q] = 1'b1;
      if (s1_vld_q && s1_wr_q && WR_MASK[s1_bank_q]) mem_wr_o[s1_bank_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      inflight_q <= '0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      s1_vld_q   <= 1'b0;
      s1_wr_q    <= 1'b0;
      s1_id_q    <= '0;
      s1_bank_q  <= '0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_rd_q    <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_id_q    <= '0;
      s2_bank_q  <= '0;
      rdata_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      ptr_q      <= ptr_d;
      s1_vld_q   <= s1_vld_d;
      s1_wr_q    <= s1_wr_d;
      s1_id_q    <= s1_id_d;
      s1_bank_q  <= s1_bank_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s2_vld_q   <= s2_vld_d;
      s2_rd_q    <= s2_rd_d;
      s2_err_q   <= s2_err_d;
      s2_id_q    <= s2_id_d;
      s2_bank_q  <= s2_bank_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_xrmem_arb_rr.sv
// Bench for xrmem_arb_rr: two instances (round-robin / all banks writable, and
// fixed priority / bank 7 read-only) driven by a vector table and random traffic.
`timescale 1ns/1ps
module tb_xrmem_arb_rr;
  localparam int NR = 3;
  localparam int NB = 8;
  localparam bit         RRM [2] = '{1'b1, 1'b0};
  localparam logic [7:0] WRM [2] = '{8'hFF, 8'h7F};

  logic             clk = 1'b0;
  logic             rst;
  logic [NB-1:0]    busy;
  logic [NB*16-1:0] rdata;
  logic [NR-1:0]    sel   [2];
  logic [NR-1:0]    wr    [2];
  logic [NR*16-1:0] addr  [2];
  logic [NR*16-1:0] wdat  [2];
  logic [NR-1:0]    ack   [2];
  logic [15:0]      rdo   [2];
  logic             err   [2];
  logic [NB-1:0]    mrd   [2];
  logic [NB-1:0]    mwr   [2];
  logic [15:0]      maddr [2];
  logic [15:0]      mdat  [2];

  always #5 clk = ~clk;

  xrmem_arb_rr #(.NUM_REQ(NR), .BANK_W(3), .RR_EN(1'b1), .WR_MASK(8'hFF)) dut_rr (
    .clk(clk), .reset_i(rst), .req_sel_i(sel[0]), .req_wr_i(wr[0]),
    .req_addr_i(addr[0]), .req_data_i(wdat[0]), .req_ack_o(ack[0]),
    .req_data_o(rdo[0]), .err_o(err[0]), .vid_busy_i(busy), .mem_rd_o(mrd[0]),
    .mem_wr_o(mwr[0]), .mem_addr_o(maddr[0]), .mem_data_o(mdat[0]), .mem_rdata_i(rdata));

  xrmem_arb_rr #(.NUM_REQ(NR), .BANK_W(3), .RR_EN(1'b0), .WR_MASK(8'h7F)) dut_fx (
    .clk(clk), .reset_i(rst), .req_sel_i(sel[1]), .req_wr_i(wr[1]),
    .req_addr_i(addr[1]), .req_data_i(wdat[1]), .req_ack_o(ack[1]),
    .req_data_o(rdo[1]), .err_o(err[1]), .vid_busy_i(busy), .mem_rd_o(mrd[1]),
    .mem_wr_o(mwr[1]), .mem_addr_o(maddr[1]), .mem_data_o(mdat[1]), .mem_rdata_i(rdata));

  // Reference: a list of accepted transactions, each with its grant cycle.
  typedef struct {
    int          inst;
    int          id;
    int          bank;
    logic [15:0] a;
    logic [15:0] d;
    bit          w;
    int          g;
  } txn_t;

  txn_t          pend [$];
  int            last_win  [2];
  logic [15:0]   last_data [2];
  logic [NR-1:0] ack_seen  [2];
  int            cyc;
  int            n_chk;
  int            n_err;

  typedef struct {
    int          inst;
    bit          rst;
    logic [2:0]  sel;
    logic [2:0]  wr;
    logic [15:0] a0, a1, a2;
    logic [7:0]  busy;
    logic [2:0]  e_ack;
    logic [7:0]  e_rd;
    logic [7:0]  e_wr;
    bit          e_err;
  } vec_t;

  vec_t        vecs [$];
  logic [15:0] ta0, ta1, ta2;

  function automatic void add(int inst, bit r, logic [2:0] s, logic [2:0] w, logic [7:0] b,
                              logic [2:0] ea, logic [7:0] erd, logic [7:0] ewr, bit ee);
    vec_t v;
    v.inst = inst; v.rst = r; v.sel = s; v.wr = w; v.busy = b;
    v.a0 = ta0; v.a1 = ta1; v.a2 = ta2;
    v.e_ack = ea; v.e_rd = erd; v.e_wr = ewr; v.e_err = ee;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic rand_rdata();
    for (int b = 0; b < NB; b++) rdata[b*16 +: 16] = 16'($urandom);
  endtask

  task automatic sample_and_check();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic [NR-1:0] e_ack;
      logic [NB-1:0] e_rd, e_wr;
      logic          e_err;
      logic [15:0]   e_addr, e_dat;
      bit            strobe, wstrobe;
      e_ack = '0; e_rd = '0; e_wr = '0; e_err = 1'b0;
      e_addr = '0; e_dat = '0; strobe = 1'b0; wstrobe = 1'b0;
      if (rst) begin
        last_data[i] = '0;
      end else begin
        foreach (pend[k]) begin
          if (pend[k].inst == i && cyc == pend[k].g + 1) begin
            if (!pend[k].w) begin
              e_rd[pend[k].bank] = 1'b1; strobe = 1'b1; e_addr = pend[k].a;
            end else if (WRM[i][pend[k].bank]) begin
              e_wr[pend[k].bank] = 1'b1; strobe = 1'b1; wstrobe = 1'b1;
              e_addr = pend[k].a; e_dat = pend[k].d;
            end
          end
          if (pend[k].inst == i && cyc == pend[k].g + 2) begin
            e_ack[pend[k].id] = 1'b1;
            if (pend[k].w && !WRM[i][pend[k].bank]) e_err = 1'b1;
            if (!pend[k].w) last_data[i] = rdata[pend[k].bank*16 +: 16];
          end
        end
      end
      chk("req_ack", i, 64'(ack[i]), 64'(e_ack));
      chk("mem_rd", i, 64'(mrd[i]), 64'(e_rd));
      chk("mem_wr", i, 64'(mwr[i]), 64'(e_wr));
      chk("err", i, 64'(err[i]), 64'(e_err));
      chk("req_data", i, 64'(rdo[i]), 64'(last_data[i]));
      if (strobe)  chk("mem_addr", i, 64'(maddr[i]), 64'(e_addr));
      if (wstrobe) chk("mem_data", i, 64'(mdat[i]), 64'(e_dat));
      ack_seen[i] = ack[i];
    end
  endtask

  task automatic advance();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = pend.size() - 1; k >= 0; k--) if (pend[k].inst == i) pend.delete(k);
        last_win[i] = NR - 1;
      end else begin
        bit elig [NR];
        int win;
        win = -1;
        for (int r = 0; r < NR; r++) begin
          int b;
          b = int'(addr[i][r*16+13 +: 3]);
          elig[r] = sel[i][r] && (wr[i][r] || !busy[b]);
          foreach (pend[k]) if (pend[k].inst == i && pend[k].id == r) elig[r] = 1'b0;
        end
        for (int k = 0; k < NR; k++) begin
          int r;
          r = RRM[i] ? (last_win[i] + 1 + k) % NR : k;
          if (win < 0 && elig[r]) win = r;
        end
        if (win >= 0) begin
          txn_t t;
          t.inst = i; t.id = win; t.g = cyc;
          t.a = addr[i][win*16 +: 16];
          t.d = wdat[i][win*16 +: 16];
          t.w = wr[i][win];
          t.bank = int'(t.a[15:13]);
          pend.push_back(t);
          last_win[i] = win;
        end
        for (int k = pend.size() - 1; k >= 0; k--)
          if (pend[k].inst == i && pend[k].g + 2 <= cyc) pend.delete(k);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    n_chk = 0; n_err = 0; cyc = 0;
    last_win = '{NR - 1, NR - 1};
    last_data = '{16'h0, 16'h0};
    ack_seen = '{'0, '0};
    rst = 1'b1; busy = '0; rdata = '0;
    for (int i = 0; i < 2; i++) begin
      sel[i] = '0; wr[i] = '0; addr[i] = '0; wdat[i] = '0;
    end

    // Three writes on the round-robin instance: grants 0,1,2 back to back.
    ta0 = 16'h8000; ta1 = 16'hA000; ta2 = 16'hC000;
    add(0, 1, 3'b000, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b111, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b111, 3'b111, 8'h00, 3'b000, 8'h00, 8'h10, 0);
    add(0, 0, 3'b111, 3'b111, 8'h00, 3'b001, 8'h00, 8'h20, 0);
    add(0, 0, 3'b110, 3'b111, 8'h00, 3'b010, 8'h00, 8'h40, 0);
    add(0, 0, 3'b100, 3'b111, 8'h00, 3'b100, 8'h00, 8'h00, 0);
    add(0, 0, 3'b000, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    // req0 re-requests while req2 arrives: fixed priority picks req0 first.
    ta0 = 16'h8000; ta1 = 16'h8100; ta2 = 16'hC000;
    add(1, 1, 3'b000, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(1, 0, 3'b011, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(1, 0, 3'b011, 3'b111, 8'h00, 3'b000, 8'h00, 8'h10, 0);
    add(1, 0, 3'b011, 3'b111, 8'h00, 3'b001, 8'h00, 8'h10, 0);
    add(1, 0, 3'b111, 3'b111, 8'h00, 3'b010, 8'h00, 8'h00, 0);
    add(1, 0, 3'b101, 3'b111, 8'h00, 3'b000, 8'h00, 8'h10, 0);
    add(1, 0, 3'b101, 3'b111, 8'h00, 3'b001, 8'h00, 8'h40, 0);
    add(1, 0, 3'b100, 3'b111, 8'h00, 3'b100, 8'h00, 8'h00, 0);
    add(1, 0, 3'b000, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    // Same traffic, round robin: req2 goes before req0's second grant.
    add(0, 1, 3'b000, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b011, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b011, 3'b111, 8'h00, 3'b000, 8'h00, 8'h10, 0);
    add(0, 0, 3'b011, 3'b111, 8'h00, 3'b001, 8'h00, 8'h10, 0);
    add(0, 0, 3'b111, 3'b111, 8'h00, 3'b010, 8'h00, 8'h00, 0);
    add(0, 0, 3'b101, 3'b111, 8'h00, 3'b000, 8'h00, 8'h40, 0);
    add(0, 0, 3'b101, 3'b111, 8'h00, 3'b100, 8'h00, 8'h10, 0);
    add(0, 0, 3'b001, 3'b111, 8'h00, 3'b001, 8'h00, 8'h00, 0);
    add(0, 0, 3'b000, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    // Read of bank 5 blocked by video for five cycles; req1 write passes.
    ta0 = 16'hA010; ta1 = 16'h8000; ta2 = 16'h0000;
    add(0, 1, 3'b000, 3'b010, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b011, 3'b010, 8'h20, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b011, 3'b010, 8'h20, 3'b000, 8'h00, 8'h10, 0);
    add(0, 0, 3'b011, 3'b010, 8'h20, 3'b010, 8'h00, 8'h00, 0);
    add(0, 0, 3'b001, 3'b010, 8'h20, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b001, 3'b010, 8'h20, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b001, 3'b010, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b001, 3'b010, 8'h00, 3'b000, 8'h20, 8'h00, 0);
    add(0, 0, 3'b001, 3'b010, 8'h00, 3'b001, 8'h00, 8'h00, 0);
    add(0, 0, 3'b000, 3'b010, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    // Write to read-only bank 7: no strobe, ack with err.
    ta0 = 16'hE000; ta1 = 16'h0000; ta2 = 16'h0000;
    add(1, 1, 3'b000, 3'b001, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(1, 0, 3'b001, 3'b001, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(1, 0, 3'b001, 3'b001, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(1, 0, 3'b001, 3'b001, 8'h00, 3'b001, 8'h00, 8'h00, 1);
    add(1, 0, 3'b000, 3'b001, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    // Reset right after a grant: nothing escapes, pointer restarts at req0.
    ta0 = 16'h8000; ta1 = 16'hA000; ta2 = 16'hC000;
    add(0, 1, 3'b000, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b010, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(0, 1, 3'b010, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b111, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b111, 3'b111, 8'h00, 3'b000, 8'h00, 8'h10, 0);
    add(0, 0, 3'b111, 3'b111, 8'h00, 3'b001, 8'h00, 8'h20, 0);
    add(0, 0, 3'b110, 3'b111, 8'h00, 3'b010, 8'h00, 8'h40, 0);
    add(0, 0, 3'b100, 3'b111, 8'h00, 3'b100, 8'h00, 8'h00, 0);
    add(0, 0, 3'b000, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    // Back-to-back reads of bank 0; data per ack checked by the model.
    ta0 = 16'h0000; ta1 = 16'h0004; ta2 = 16'h0000;
    add(0, 1, 3'b000, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b011, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0);
    add(0, 0, 3'b011, 3'b000, 8'h00, 3'b000, 8'h01, 8'h00, 0);
    add(0, 0, 3'b011, 3'b000, 8'h00, 3'b001, 8'h01, 8'h00, 0);
    add(0, 0, 3'b010, 3'b000, 8'h00, 3'b010, 8'h00, 8'h00, 0);
    add(0, 0, 3'b000, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0);

    foreach (vecs[n]) begin
      v = vecs[n];
      rst = v.rst;
      busy = v.busy;
      rand_rdata();
      for (int i = 0; i < 2; i++) begin
        sel[i]  = (i == v.inst) ? v.sel : 3'b000;
        wr[i]   = v.wr;
        addr[i] = {v.a2, v.a1, v.a0};
        wdat[i] = {16'h3333, 16'h2222, 16'h1111} ^ {3{cyc[15:0]}};
      end
      sample_and_check();
      chk($sformatf("vec%0d_ack", n), v.inst, 64'(ack[v.inst]), 64'(v.e_ack));
      chk($sformatf("vec%0d_rd", n), v.inst, 64'(mrd[v.inst]), 64'(v.e_rd));
      chk($sformatf("vec%0d_wr", n), v.inst, 64'(mwr[v.inst]), 64'(v.e_wr));
      chk($sformatf("vec%0d_err", n), v.inst, 64'(err[v.inst]), 64'(v.e_err));
      advance();
    end

    // Random traffic: requesters hold until ack, drop for a cycle, then maybe reissue.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) sel[i] = '0;
    sample_and_check();
    advance();
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < NB; b++) busy[b] = ($urandom_range(0, 3) == 0);
      rand_rdata();
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < NR; r++) begin
          if (ack_seen[i][r]) begin
            sel[i][r] = 1'b0;
          end else if (!sel[i][r] && $urandom_range(0, 1) == 1) begin
            sel[i][r] = 1'b1;
            wr[i][r] = 1'($urandom_range(0, 1));
            addr[i][r*16 +: 16] = 16'($urandom);
            wdat[i][r*16 +: 16] = 16'($urandom);
          end
        end
      end
      sample_and_check();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/xrmem_arb_rr.md
Name: xrmem_arb_rr

Overview:
Parametrised N-requester XR memory/register arbiter with a banked router. It replaces fixed copper-first, regs-second arbitration with configurable fixed or round-robin priority, and a registered, pipelined grant path. It sits between XR bus masters (register interface, copper, future blitter) and the XR banks (regs, colormem, tilemem, coppermem). Video fetch stays the owner of each bank's read port and may block reads on a per-bank basis.

Parameters:
NUM_REQ, 3, number of XR requesters (index 0 = highest fixed priority)
BANK_W, 3, bank index = addr[15:16-BANK_W]; NUM_BANK = 2**BANK_W
RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority
WR_MASK, 8'hFF, bit b set = bank b writable

Ports:
clk  in  1  system clock
reset_i  in  1  synchronous active-high reset
req_sel_i  in  NUM_REQ  request valid, held until ack
req_wr_i  in  NUM_REQ  1 = write, 0 = read
req_addr_i  in  NUM_REQ*16  XR address, packed, requester r at [r*16+:16]
req_data_i  in  NUM_REQ*16  write data, packed
req_ack_o  out  NUM_REQ  one-cycle completion pulse
req_data_o  out  16  read data, valid with the matching ack
err_o  out  1  one-cycle pulse on a write to a non-writable bank
vid_busy_i  in  NUM_BANK  video owns bank read port this cycle
mem_rd_o  out  NUM_BANK  bank read strobe (one-hot or zero)
mem_wr_o  out  NUM_BANK  bank write strobe (one-hot or zero)
mem_addr_o  out  16  bank address
mem_data_o  out  16  bank write data
mem_rdata_i  in  NUM_BANK*16  bank read data, valid 1 cycle after mem_rd_o

Behaviour:
Reset:
- All outputs are 0.
- In-flight transactions are dropped and never acked.
- The round-robin pointer is set to NUM_REQ-1, so requester 0 wins first.

Eligibility (cycle G):
- Requester r is eligible when req_sel_i[r] is 1, it is not in flight (inflight_q[r] = 0), and its ack is not asserted this cycle.
- A read to bank b is masked while vid_busy_i[b] = 1. Writes ignore vid_busy_i.

Arbitration:
- At most one grant per cycle.
- RR_EN=0: the lowest eligible index wins.
- RR_EN=1: the search starts at ptr+1 and wraps modulo NUM_REQ. ptr updates to the winner only on a grant.
- No grant, no state change.

Pipeline:
- Cycle G: grant; register bank, addr, data, wr and requester id; set inflight_q[r].
- Cycle G+1: mem_rd_o / mem_wr_o[bank] = 1 for exactly one cycle, together with mem_addr_o / mem_data_o.
- Cycle G+2: req_ack_o[r] = 1. For reads, req_data_o = mem_rdata_i[bank] sampled at G+2. Clear inflight_q[r].
- Fixed latency: ack 2 cycles after grant for both reads and writes.
- Throughput: one grant per cycle across different requesters.

Write to a bank with WR_MASK[b] = 0:
- No mem_wr_o.
- Ack still at G+2.
- err_o pulses at G+2.

Handshake rules:
- The requester drops or changes sel the cycle after ack. The arbiter does not regrant r in its ack cycle.
- Read and write strobes are never both set in one cycle.
- req_data_o holds its last value when no read ack is present.

Starvation bound:
- With RR_EN=1, any continuously eligible requester is granted within NUM_REQ cycles.
- A read blocked by vid_busy_i waits without bound while the bank stays busy. Other requesters proceed meanwhile.

Reset mid-operation:
- Synchronous reset overrides the pipeline registers in the same edge.
- No strobe or ack appears in the following cycle.

Test Plan:
1. RR_EN=1, NUM_REQ=3, all three issue writes at cycle 0 to 0x8000, 0xA000, 0xC000 → grants 0,1,2 at cycles 0,1,2. mem_wr_o bits 4,5,6 at cycles 1,2,3. Acks at cycles 2,3,4.
2. Same traffic with RR_EN=0 and req0 re-requesting each time its ack drops → req0 is granted again at cycle 3, before req2. With RR_EN=1, req2 is granted before req0's second grant.
3. Read of 0xA010 with vid_busy_i[5]=1 for cycles 0-4 → no mem_rd_o until cycle 6. Ack at cycle 7 with req_data_o = mem_rdata_i[5*16+:16]. A req1 write to bank 4 during cycles 0-4 completes unblocked.
4. WR_MASK=8'h7F, write to 0xE000 → no mem_wr_o. Ack and err_o=1 at cycle 2.
5. reset_i=1 in the cycle after a grant → mem_*_o, req_ack_o and err_o stay 0. After release, ptr restarts so req0 wins first.
6. Back-to-back reads by req0 and req1 to bank 0 → reads at cycles 1 and 2, each ack carries its own bank data, and req_data_o does not cross-contaminate.
